// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// ALU control codes, mux selects and the decoded instruction class.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_LUI   = 2'b11;

    // ALU B operand: register, constant 4, sign-extended imm, shifted imm.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_LUIEX  = 4'd10,
        S_LUIWB  = 4'd11
    } state_t;

    typedef struct packed {
        logic is_r;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_lui;
        logic is_j;
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_ctr;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Signal bundle between the multicycle controller (master) and its datapath/memory (slave).
// mem_ready: a memory access completes in the cycle mem_ready is high; until then the
// controller holds its state and outputs (only wired when MEM_WAIT_EN is defined).
interface multicycle_control_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_ctr;
    logic       illegal_op;
    logic       pc_en;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, pc_write_cond, ior_d, ir_write, mem_read, mem_write,
               memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_ctr, illegal_op, pc_en, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, pc_write_cond, ior_d, ir_write, mem_read, mem_write,
               memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_ctr, illegal_op, pc_en, state
    );
endinterface

// File: rtl/mc_opdecode.sv
// Opcode decoder: one-hot instruction class plus an illegal flag when no class matches.
module mc_opdecode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    output op_class_t  o_cls,
    output logic       o_illegal
);

    always_comb begin
        o_cls = '0;
        case (i_op)
            OP_R:    o_cls.is_r   = 1'b1;
            OP_LW:   o_cls.is_lw  = 1'b1;
            OP_SW:   o_cls.is_sw  = 1'b1;
            OP_BEQ:  o_cls.is_beq = 1'b1;
            OP_LUI:  o_cls.is_lui = 1'b1;
            OP_J:    o_cls.is_j   = 1'b1;
            default: ;
        endcase
    end

    assign o_illegal = (o_cls == '0);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath. Optional MEM_WAIT_EN adds a
// mem_ready input that stretches FETCH, MEMRD and MEMWR until memory completes.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic               zero,
`ifdef MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               illegal_op,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUctr,
    output logic               pc_en,
    output logic [STATE_W-1:0] state
);

    state_t    r_state;
    state_t    w_next;
    ctrl_t     w_ctrl;
    op_class_t w_cls;
    logic      w_illegal;
    logic      w_ready;

`ifdef MEM_WAIT_EN
    assign w_ready = mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    mc_opdecode u_opdecode (
        .i_op      (op),
        .o_cls     (w_cls),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_cls.is_lw || w_cls.is_sw) w_next = S_MEMADR;
                else if (w_cls.is_r)            w_next = S_EXEC;
                else if (w_cls.is_beq)          w_next = S_BRANCH;
                else if (w_cls.is_j)            w_next = S_JUMP;
                else if (w_cls.is_lui)          w_next = S_LUIEX;
                else                            w_next = S_FETCH;
            end
            S_MEMADR: w_next = w_cls.is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_LUIEX:  w_next = S_LUIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Control word per state; write enables are forced low while reset is held.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ir_write  = w_ready;
                w_ctrl.pc_write  = w_ready;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_ctr   = ALU_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_BROFF;
                w_ctrl.alu_ctr   = ALU_ADD;
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_ctr   = ALU_ADD;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.memto_reg = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REG;
                w_ctrl.alu_ctr   = ALU_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_REG;
                w_ctrl.alu_ctr       = ALU_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_BR;
            end
            S_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_JMP;
            end
            S_LUIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_ctr   = ALU_LUI;
            end
            S_LUIWB:  w_ctrl.reg_write = 1'b1;
            default:  ;
        endcase
        if (rst) begin
            w_ctrl.pc_write      = 1'b0;
            w_ctrl.pc_write_cond = 1'b0;
            w_ctrl.ir_write      = 1'b0;
            w_ctrl.mem_write     = 1'b0;
            w_ctrl.reg_write     = 1'b0;
        end
    end

    assign PCWrite     = w_ctrl.pc_write;
    assign PCWriteCond = w_ctrl.pc_write_cond;
    assign IorD        = w_ctrl.ior_d;
    assign IRWrite     = w_ctrl.ir_write;
    assign MemRead     = w_ctrl.mem_read;
    assign MemWrite    = w_ctrl.mem_write;
    assign MemtoReg    = w_ctrl.memto_reg;
    assign RegDst      = w_ctrl.reg_dst;
    assign RegWrite    = w_ctrl.reg_write;
    assign ALUSrcA     = w_ctrl.alu_src_a;
    assign ALUSrcB     = w_ctrl.alu_src_b;
    assign PCSource    = w_ctrl.pc_source;
    assign ALUctr      = w_ctrl.alu_ctr;
    assign illegal_op  = (r_state == S_DECODE) && w_illegal;
    assign pc_en       = w_ctrl.pc_write | (w_ctrl.pc_write_cond & zero);
    assign state       = STATE_W'(r_state);

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: STATE_W, 4, width of the state register.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: op  input  6  opcode field from the instruction register.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have ports, all outputs, width 1: PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op.
REQ-007 SHALL have ports, all outputs, width 2: ALUSrcB, PCSource, ALUctr.
REQ-008 SHALL have port: pc_en  output  1  PCWrite | (PCWriteCond & zero).
REQ-009 SHALL have port: state  output  STATE_W  current state, debug only.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, LUIEX, LUIWB.
REQ-011 SHALL decode opcodes exactly: R 000000, lw 100011, sw 101011, beq 000100, lui 001111, j 000010.
REQ-012 SHALL use ALUctr encoding: 00 add, 01 sub, 10 funct-decoded (R-type), 11 lui shift.
REQ-013 FETCH SHALL assert MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUctr=00, PCSource=00, IorD=0, then go to DECODE.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUctr=00 (branch target), and branch to MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), or LUIEX (lui).
REQ-015 DECODE with any other opcode SHALL assert illegal_op for that cycle and return to FETCH.
REQ-016 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUctr=00; next MEMRD (lw) or MEMWR (sw).
REQ-017 MEMRD SHALL assert MemRead, IorD=1, then go to MEMWB; MEMWB SHALL assert RegWrite, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-018 MEMWR SHALL assert MemWrite, IorD=1, then go to FETCH.
REQ-019 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUctr=10; ALUWB SHALL assert RegWrite, RegDst=1, MemtoReg=0; then FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUctr=01, PCWriteCond=1, PCSource=01; then FETCH.
REQ-021 JUMP SHALL assert PCWrite, PCSource=10; then FETCH.
REQ-022 LUIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUctr=11; LUIWB SHALL assert RegWrite, RegDst=0, MemtoReg=0; then FETCH.
REQ-023 Every output not listed for a state SHALL be 0 in that state.
REQ-024 Latency in cycles, FETCH to FETCH inclusive: lw 5, sw 4, R 4, lui 4, beq 3, j 3.
REQ-025 Outputs SHALL be functions of state only; illegal_op and the DECODE next-state may also depend on op.

Reset
REQ-026 rst=1 at a clock edge SHALL force state=FETCH, regardless of current state, including mid-instruction.
REQ-027 While rst=1, all write-enable outputs (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) SHALL be 0.
REQ-028 In the first cycle after rst deasserts, FETCH outputs SHALL be driven.

Configuration
REQ-029 Macro MEM_WAIT_EN defined: add input mem_ready (1 bit); FETCH, MEMRD and MEMWR SHALL hold state and hold outputs until mem_ready=1, and PCWrite/IRWrite in FETCH SHALL be qualified by mem_ready.
REQ-030 MEM_WAIT_EN undefined: no mem_ready port; every state SHALL last exactly one cycle.

Structure
REQ-031 Opcode constants, the state enumeration and the ALUctr encodings SHALL reside in shared package mips_ctrl_pkg.
REQ-032 Opcode decode SHALL be a sub-module mc_opdecode (op in, one-hot instruction class plus illegal flag out).

Verification
REQ-033 Reset in EXEC -> next cycle state=FETCH; MemWrite=RegWrite=0 throughout.
REQ-034 op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-035 op=000100, zero=1 -> pc_en=1 in BRANCH; with zero=0 -> pc_en=0; both 3 cycles.
REQ-036 op=111111 -> illegal_op=1 in DECODE; next state FETCH; no write enables asserted.
REQ-037 op=001111 -> ALUctr=11 in LUIEX, RegWrite=1 in LUIWB, back-to-back with op=000010 giving PCSource=10 in JUMP.
REQ-038 MEM_WAIT_EN, mem_ready low 3 cycles in MEMRD -> state held 4 cycles, MemRead held, no RegWrite until MEMWB.
